gfx_wr_arbiter: RTL

- Shares one DDR write path (address FIFO af_* plus write-data FIFO wdf_*) between two graphics requesters: r0 is the line engine, r1 is the frame filler.
- Each requester drives a FIFO-style interface: an address beat, then data beats, with per-requester full back-pressure.
- Grants whole bursts round-robin, so address and data entries from different requesters never interleave.
- Sits between the graphics engines and the memory-controller request FIFOs.

---
 rtl/gfx_pkg.sv | 23 ++
 rtl/gfx_rr_pick2.sv | 20 ++
 rtl/gfx_wr_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics write-path arbiter: default widths,
// arbiter state encoding and the "nothing written" byte-mask constant.
package gfx_pkg;

    localparam int ADDR_W      = 31;
    localparam int DATA_W      = 128;
    localparam int MASK_W      = 16;
    localparam int BURST_BEATS = 2;

    // Mask bits are active-high (1 = byte masked), so all ones writes nothing.
    localparam logic [MASK_W-1:0] MASK_NONE = '1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // One-hot grant vector for a requester index (0 -> 01, 1 -> 10).
    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/gfx_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright; on a tie the
// requester that did not own the previous burst wins.
module gfx_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] win_o
);

    // Pure combinational pick; last_owner_i = 1 means r1 owned the last burst.
    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = last_owner_i ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/gfx_wr_arbiter.sv
// Shares one DDR write path (address FIFO + write-data FIFO) between the line
// engine (r0) and the frame filler (r1). Whole bursts are granted round-robin
// so address/data entries of the two requesters never interleave.
module gfx_wr_arbiter #(
    parameter int ADDR_W      = gfx_pkg::ADDR_W,
    parameter int DATA_W      = gfx_pkg::DATA_W,
    parameter int MASK_W      = gfx_pkg::MASK_W,
    parameter int BURST_BEATS = gfx_pkg::BURST_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r0_af_addr_din,
    input  logic              r0_af_wr_en,
    input  logic [DATA_W-1:0] r0_wdf_din,
    input  logic [MASK_W-1:0] r0_wdf_mask_din,
    input  logic              r0_wdf_wr_en,
    output logic              r0_af_full,
    output logic              r0_wdf_full,
    input  logic [ADDR_W-1:0] r1_af_addr_din,
    input  logic              r1_af_wr_en,
    input  logic [DATA_W-1:0] r1_wdf_din,
    input  logic [MASK_W-1:0] r1_wdf_mask_din,
    input  logic              r1_wdf_wr_en,
    output logic              r1_af_full,
    output logic              r1_wdf_full,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              af_wr_en,
    output logic [DATA_W-1:0] wdf_din,
    output logic [MASK_W-1:0] wdf_mask_din,
    output logic              wdf_wr_en,
    output logic [1:0]        grant,
    output logic              busy
);
    import gfx_pkg::*;

    localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

    arb_state_t       state_q;
    logic             owner_q;
    logic             last_owner_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [1:0]       grant_q;
    logic             busy_q;

    // Per-requester views so the owner can be selected by index.
    logic [1:0]        req_af_en;
    logic [1:0]        req_wdf_en;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [MASK_W-1:0] req_mask [2];
    logic [1:0]        rq_af_full;
    logic [1:0]        rq_wdf_full;
    logic [1:0]        pick_win;

    assign req_af_en   = {r1_af_wr_en, r0_af_wr_en};
    assign req_wdf_en  = {r1_wdf_wr_en, r0_wdf_wr_en};
    assign req_addr[0] = r0_af_addr_din;
    assign req_addr[1] = r1_af_addr_din;
    assign req_data[0] = r0_wdf_din;
    assign req_data[1] = r1_wdf_din;
    assign req_mask[0] = r0_wdf_mask_din;
    assign req_mask[1] = r1_wdf_mask_din;

    gfx_rr_pick2 u_pick (
        .req_i        (req_af_en),
        .last_owner_i (last_owner_q),
        .win_o        (pick_win)
    );

    logic in_own;
    logic first_beat;
    logic head_ok;
    logic tail_ok;
    logic beat_acc;

    assign in_own     = (state_q == OWN);
    assign first_beat = (beat_cnt_q == '0);
    // Address and first data beat only move together, and only when both
    // downstream FIFOs have room.
    assign head_ok    = req_af_en[owner_q] & req_wdf_en[owner_q] & ~af_full & ~wdf_full;
    assign tail_ok    = req_wdf_en[owner_q] & ~wdf_full;
    assign beat_acc   = in_own & (first_beat ? head_ok : tail_ok);

    assign af_wr_en  = in_own & first_beat & head_ok;
    assign wdf_wr_en = beat_acc;

    // Back-pressure: everyone but the current owner sees both FIFOs full.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic is_owner;
        assign is_owner        = in_own & (owner_q == 1'(gi));
        assign rq_af_full[gi]  = is_owner ? (first_beat ? (af_full | wdf_full) : 1'b1)     : 1'b1;
        assign rq_wdf_full[gi] = is_owner ? (first_beat ? (af_full | wdf_full) : wdf_full) : 1'b1;
    end

    assign r0_af_full  = rq_af_full[0];
    assign r0_wdf_full = rq_wdf_full[0];
    assign r1_af_full  = rq_af_full[1];
    assign r1_wdf_full = rq_wdf_full[1];

    // Route the owner's address/data/mask downstream; drive inert values when idle.
    always_comb begin
        af_addr_din  = '0;
        wdf_din      = '0;
        wdf_mask_din = {MASK_W{MASK_NONE[0]}};
        if (in_own) begin
            af_addr_din  = req_addr[owner_q];
            wdf_din      = req_data[owner_q];
            wdf_mask_din = req_mask[owner_q];
        end
    end

    // Burst ownership FSM: latch a winner in IDLE, release after the last beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            beat_cnt_q   <= '0;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    if (|pick_win) begin
                        state_q <= OWN;
                        owner_q <= pick_win[1];
                        grant_q <= onehot2(pick_win[1]);
                        busy_q  <= 1'b1;
                    end
                end
                OWN: begin
                    if (beat_acc) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q      <= IDLE;
                            beat_cnt_q   <= '0;
                            last_owner_q <= owner_q;
                            grant_q      <= 2'b00;
                            busy_q       <= 1'b0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule
